// File: rtl/spram_pwr_ctrl.sv
// Power-state sequencer and access gate for one SPRAM wrapper instance.
// Idle periods step the RAM through standby and sleep; a request wakes it and stalls.
module spram_pwr_ctrl #(
  parameter int unsigned LS_IDLE = 16,
  parameter int unsigned DS_IDLE = 256,
  parameter int unsigned WAKE_LS = 1,
  parameter int unsigned WAKE_DS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sleep_en_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [13:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        ram_sel_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [13:0] ram_addr_o,
  output logic [31:0] ram_din_o,
  input  logic [31:0] ram_dout_i,
  output logic        ls_req_o,
  output logic        ds_req_o,
  output logic [1:0]  pwr_state_o
);

  localparam int unsigned MAX_A   = (LS_IDLE > DS_IDLE) ? LS_IDLE : DS_IDLE;
  localparam int unsigned MAX_CNT = (MAX_A > WAKE_DS) ? MAX_A : WAKE_DS;
  localparam int unsigned CW      = $clog2(MAX_CNT) + 1;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_SLEEP   = 2'd2,
    ST_WAKE    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] wake_cnt_q, wake_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          ls_req_q, ls_req_d;
  logic          ds_req_q, ds_req_d;

  // Access gate: requests pass straight through only while awake
  assign ready_o     = req_i & (state_q == ST_ACTIVE);
  assign ram_sel_o   = ready_o;
  assign ram_we_o    = we_i & ready_o;
  assign ram_be_o    = be_i;
  assign ram_addr_o  = addr_i;
  assign ram_din_o   = wdata_i;
  assign rdata_o     = ram_dout_i;
  assign rvalid_o    = rvalid_q;
  assign ls_req_o    = ls_req_q;
  assign ds_req_o    = ds_req_q;
  assign pwr_state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      ls_req_q   <= 1'b0;
      ds_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      rvalid_q   <= rvalid_d;
      ls_req_q   <= ls_req_d;
      ds_req_q   <= ds_req_d;
    end
  end

  // Next-state logic; power requests follow the next state so they align with pwr_state
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    rvalid_d   = ready_o & ~we_i;

    unique case (state_q)
      ST_ACTIVE: begin
        if (req_i || !sleep_en_i) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CW'(LS_IDLE - 1)) begin
          state_d    = ST_STANDBY;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      ST_STANDBY: begin
        if (req_i || !sleep_en_i) begin
          state_d    = ST_WAKE;
          wake_cnt_d = CW'(WAKE_LS - 1);
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CW'(DS_IDLE - 1)) begin
          state_d    = ST_SLEEP;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      ST_SLEEP: begin
        if (req_i || !sleep_en_i) begin
          state_d    = ST_WAKE;
          wake_cnt_d = CW'(WAKE_DS - 1);
        end
      end
      ST_WAKE: begin
        // Wake always runs to completion, even if the request is withdrawn
        if (wake_cnt_q == '0) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - CW'(1);
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    ls_req_d = (state_d == ST_STANDBY);
    ds_req_d = (state_d == ST_SLEEP);
  end

endmodule

// File: tb/tb_spram_pwr_ctrl.sv
// Directed bench for spram_pwr_ctrl: power-down timing, wake latency, pass-through and reset.
module tb_spram_pwr_ctrl;

  logic        clk = 1'b0;
  logic        rst, sleep_en, req, we;
  logic [3:0]  be;
  logic [13:0] addr;
  logic [31:0] wdata, ram_dout;
  logic        ready, rvalid, ram_sel, ram_we, ls_req, ds_req;
  logic [31:0] rdata, ram_din;
  logic [3:0]  ram_be;
  logic [13:0] ram_addr;
  logic [1:0]  pwr_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spram_pwr_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sleep_en_i  (sleep_en),
    .req_i       (req),
    .we_i        (we),
    .be_i        (be),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .ready_o     (ready),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .ram_sel_o   (ram_sel),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout),
    .ls_req_o    (ls_req),
    .ds_req_o    (ds_req),
    .pwr_state_o (pwr_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_pwr(input string tag, input logic [1:0] st, input logic ls, input logic ds);
    chk({tag, "_state"}, 32'(pwr_state), 32'(st));
    chk({tag, "_ls"}, 32'(ls_req), 32'(ls));
    chk({tag, "_ds"}, 32'(ds_req), 32'(ds));
  endtask

  initial begin
    rst = 1'b1; sleep_en = 1'b1; req = 1'b0; we = 1'b0;
    be = 4'h0; addr = 14'h0; wdata = 32'h0; ram_dout = 32'h0;
    ticks(2);
    rst = 1'b0;
    #1;
    // Reset state, cycle 0
    chk_pwr("rst", 2'd0, 1'b0, 1'b0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);

    // T1: idle power-down
    ticks(15);
    chk_pwr("t1_c15", 2'd0, 1'b0, 1'b0);
    tick();
    chk_pwr("t1_c16", 2'd1, 1'b1, 1'b0);
    ticks(255);
    chk_pwr("t1_c271", 2'd1, 1'b1, 1'b0);
    tick();
    chk_pwr("t1_c272", 2'd2, 1'b0, 1'b1);

    // T3b: request in SLEEP stalls 4 WAKE cycles
    req = 1'b1; we = 1'b0; addr = 14'h0020;
    #1;
    chk("t3b_sleep_ready", 32'(ready), 32'd0);
    chk("t3b_sleep_sel", 32'(ram_sel), 32'd0);
    tick();
    chk_pwr("t3b_w1", 2'd3, 1'b0, 1'b0);
    chk("t3b_w1_ready", 32'(ready), 32'd0);
    tick();
    chk("t3b_w2", 32'(pwr_state), 32'd3);
    tick();
    chk("t3b_w3", 32'(pwr_state), 32'd3);
    tick();
    chk("t3b_w4", 32'(pwr_state), 32'd3);
    chk("t3b_w4_ready", 32'(ready), 32'd0);
    tick();
    chk("t3b_act", 32'(pwr_state), 32'd0);
    chk("t3b_ready", 32'(ready), 32'd1);
    chk("t3b_addr", 32'(ram_addr), 32'h20);
    tick();
    req = 1'b0;
    #1;
    chk("t3b_rvalid", 32'(rvalid), 32'd1);

    // T4: request in the threshold cycle keeps ACTIVE
    ticks(15);
    chk("t4_c15_state", 32'(pwr_state), 32'd0);
    req = 1'b1; we = 1'b1; be = 4'hA; addr = 14'h1234; wdata = 32'hDEAD_BEEF;
    #1;
    chk("t4_ready", 32'(ready), 32'd1);
    chk("t4_ram_we", 32'(ram_we), 32'd1);
    chk("t4_ram_be", 32'(ram_be), 32'hA);
    chk("t4_ram_din", ram_din, 32'hDEAD_BEEF);
    chk("t4_ram_addr", 32'(ram_addr), 32'h1234);
    tick();
    req = 1'b0; we = 1'b0;
    #1;
    chk_pwr("t4_after", 2'd0, 1'b0, 1'b0);
    chk("t4_rvalid_wr", 32'(rvalid), 32'd0);
    ticks(15);
    chk("t4_idle_c15", 32'(pwr_state), 32'd0);
    tick();
    chk_pwr("t4_standby", 2'd1, 1'b1, 1'b0);

    // T3a: request in STANDBY -> 1 WAKE cycle; T2 read pass-through
    req = 1'b1; we = 1'b0; addr = 14'h0010;
    #1;
    chk("t3a_sb_ready", 32'(ready), 32'd0);
    tick();
    chk_pwr("t3a_wake", 2'd3, 1'b0, 1'b0);
    chk("t3a_wake_ready", 32'(ready), 32'd0);
    tick();
    chk("t2_ready", 32'(ready), 32'd1);
    chk("t2_sel", 32'(ram_sel), 32'd1);
    chk("t2_we", 32'(ram_we), 32'd0);
    chk("t2_addr", 32'(ram_addr), 32'h10);
    chk("t2_rvalid_pre", 32'(rvalid), 32'd0);
    tick();
    req = 1'b0; ram_dout = 32'hCAFE_BABE;
    #1;
    chk("t2_rvalid", 32'(rvalid), 32'd1);
    chk("t2_rdata", rdata, 32'hCAFE_BABE);
    tick();
    chk("t2_rvalid_off", 32'(rvalid), 32'd0);

    // T5: sleep_en dropped in SLEEP
    ticks(15);
    chk("t5_sb", 32'(pwr_state), 32'd1);
    ticks(256);
    chk_pwr("t5_sleep", 2'd2, 1'b0, 1'b1);
    sleep_en = 1'b0;
    tick();
    chk_pwr("t5_wake", 2'd3, 1'b0, 1'b0);
    ticks(3);
    chk("t5_wake4", 32'(pwr_state), 32'd3);
    tick();
    chk("t5_active", 32'(pwr_state), 32'd0);
    ticks(300);
    chk_pwr("t5_hold", 2'd0, 1'b0, 1'b0);

    // T6: reset while asleep
    sleep_en = 1'b1;
    ticks(16);
    chk("t6_sb", 32'(pwr_state), 32'd1);
    ticks(256);
    chk_pwr("t6_sleep", 2'd2, 1'b0, 1'b1);
    rst = 1'b1; req = 1'b1; we = 1'b0;
    #1;
    chk("t6_pre_ready", 32'(ready), 32'd0);
    tick();
    chk_pwr("t6_rst", 2'd0, 1'b0, 1'b0);
    chk("t6_rvalid", 32'(rvalid), 32'd0);
    chk("t6_ready", 32'(ready), 32'd1);
    rst = 1'b0; req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
